// File: rtl/alk_pkg.sv
// alk_pkg: shared definitions for the ALK shifter control path.
//   - ALUSHF micro-op codes driven to the ALK
//   - shift mode encoding as presented by the microsequencer
//   - shift sequencer state encoding
package alk_pkg;

  localparam logic [2:0] ALUSHF_NOP  = 3'b000;
  localparam logic [2:0] ALUSHF_QSI1 = 3'b001; // right 1, fill from Q (=0)
  localparam logic [2:0] ALUSHF_SHF  = 3'b010; // left 1
  localparam logic [2:0] ALUSHF_ROT  = 3'b011; // rotate left 1
  localparam logic [2:0] ALUSHF_ASR1 = 3'b100; // right 1, sign fill
  localparam logic [2:0] ALUSHF_WB30 = 3'b110; // write-back

  typedef enum logic [1:0] {
    MODE_LOG  = 2'b00,
    MODE_ARI  = 2'b01,
    MODE_ROT  = 2'b10,
    MODE_LOG2 = 2'b11  // treated as logical
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FIN   = 2'b10
  } state_e;

endpackage

// File: rtl/alk_shfcnt.sv
// alk_shfcnt: step down-counter for the shift sequencer.
//   clk, reset_h  clock, synchronous active-high reset (count -> 0)
//   clr_h         cancel: count -> 0 (wins over hold)
//   hold_h        freeze the count
//   load_h        load load_val
//   dec_h         decrement (saturates at zero)
//   is_one        count == 1 (last step is being issued)
//   is_zero       count == 0
module alk_shfcnt #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset_h,
  input  logic         clr_h,
  input  logic         hold_h,
  input  logic         load_h,
  input  logic [W-1:0] load_val,
  input  logic         dec_h,
  output logic         is_one,
  output logic         is_zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_h)                     cnt_d = '0;
    else if (hold_h)               cnt_d = cnt_q;
    else if (load_h)               cnt_d = load_val;
    else if (dec_h && !is_zero)    cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset_h) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign is_one  = (cnt_q == W'(1));
  assign is_zero = (cnt_q == '0);

endmodule

// File: rtl/alk_shfseq.sv
// alk_shfseq: multi-cycle shift sequencer for the ALK shifter.
// Takes one shift request (signed count, mode), issues one single-bit ALUSHF
// step per cycle, then a WB30 write-back cycle with a done pulse. Tracks
// overflow (sign-bit change) for arithmetic left shifts.
//   clk, reset_h  clock, synchronous active-high reset
//   start_h       request, accepted only in IDLE
//   cnt_h         signed count (+left / -right), sampled on accept
//   mode_h        00 logical, 01 arithmetic, 10 rotate, 11 logical
//   stall_h       freeze state, counter and outputs
//   abort_h       cancel the in-flight sequence
//   msb_chg_h     datapath: sign bit changed on the current step
//   busy_h        high in SHIFT and FIN
//   alushf_h      ALUSHF micro-op to the ALK (registered)
//   done_h        completion pulse (held while stalled in FIN)
//   ovf_h         overflow, valid with done_h
module alk_shfseq
  import alk_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int DP_W  = 32
) (
  input  logic             clk,
  input  logic             reset_h,
  input  logic             start_h,
  input  logic [CNT_W-1:0] cnt_h,
  input  logic [1:0]       mode_h,
  input  logic             stall_h,
  input  logic             abort_h,
  input  logic             msb_chg_h,
  output logic             busy_h,
  output logic [2:0]       alushf_h,
  output logic             done_h,
  output logic             ovf_h
);

  localparam logic signed [CNT_W:0] DPW_S = DP_W[CNT_W:0];

  // One extra bit so that -2^(CNT_W-1) has a representable magnitude.
  logic signed [CNT_W:0] n_ext, rot_r;
  logic [CNT_W:0]        mag, ld_steps;
  logic [2:0]            ld_code;
  logic                  ld_trk;

  always_comb begin
    n_ext = {cnt_h[CNT_W-1], cnt_h};
    mag   = n_ext[CNT_W] ? -n_ext : n_ext;
    // Right rotate by k is a left rotate by DP_W-k: fold into [0, DP_W).
    rot_r = n_ext % DPW_S;
    if (rot_r[CNT_W]) rot_r = rot_r + DPW_S;
    ld_trk = 1'b0;
    case (mode_e'(mode_h))
      MODE_ROT: begin
        ld_steps = rot_r;
        ld_code  = ALUSHF_ROT;
      end
      MODE_ARI: begin
        ld_steps = mag;
        ld_code  = n_ext[CNT_W] ? ALUSHF_ASR1 : ALUSHF_SHF;
        ld_trk   = !n_ext[CNT_W] && (mag != '0);
      end
      default: begin
        ld_steps = mag;
        ld_code  = n_ext[CNT_W] ? ALUSHF_QSI1 : ALUSHF_SHF;
      end
    endcase
  end

  state_e     state_q, state_d;
  logic [2:0] alushf_q, alushf_d;
  logic       done_q, done_d;
  logic       ovf_q, ovf_d;
  logic       trk_q, trk_d;   // overflow tracking enabled for this op
  logic       ld_en, dec_en, cnt_one, cnt_zero;

  alk_shfcnt #(.W(CNT_W + 1)) u_cnt (
    .clk      (clk),
    .reset_h  (reset_h),
    .clr_h    (abort_h),
    .hold_h   (stall_h),
    .load_h   (ld_en),
    .load_val (ld_steps),
    .dec_h    (dec_en),
    .is_one   (cnt_one),
    .is_zero  (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    alushf_d = alushf_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    trk_d    = trk_q;
    ld_en    = 1'b0;
    dec_en   = 1'b0;
    if (abort_h) begin
      state_d  = ST_IDLE;
      alushf_d = ALUSHF_NOP;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      trk_d    = 1'b0;
    end else if (!stall_h) begin
      case (state_q)
        ST_IDLE: begin
          if (start_h) begin
            ld_en = 1'b1;
            trk_d = ld_trk;
            ovf_d = 1'b0;
            if (ld_steps == '0) begin
              state_d  = ST_FIN;
              alushf_d = ALUSHF_WB30;
              done_d   = 1'b1;
            end else begin
              state_d  = ST_SHIFT;
              alushf_d = ld_code;
            end
          end
        end
        ST_SHIFT: begin
          dec_en = 1'b1;
          if (trk_q && msb_chg_h) ovf_d = 1'b1;
          // Step code is already on alushf_q; it simply holds until the last step.
          if (cnt_one || cnt_zero) begin
            state_d  = ST_FIN;
            alushf_d = ALUSHF_WB30;
            done_d   = 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          alushf_d = ALUSHF_NOP;
          done_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_h) begin
      state_q  <= ST_IDLE;
      alushf_q <= ALUSHF_NOP;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      trk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      alushf_q <= alushf_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      trk_q    <= trk_d;
    end
  end

  assign busy_h   = (state_q != ST_IDLE);
  assign alushf_h = alushf_q;
  assign done_h   = done_q;
  assign ovf_h    = ovf_q;

endmodule

// File: tb/tb_alk_shfseq.sv
// Scoreboard bench for alk_shfseq: the driver pushes the expected outcome of
// each accepted request; a negedge monitor checks the DUT's step stream and
// completion against the queue head.
module tb_alk_shfseq;

  logic       clk = 1'b0;
  logic       reset_h, start_h, stall_h, abort_h, msb_chg_h;
  logic [5:0] cnt_h;
  logic [1:0] mode_h;
  logic       busy_h, done_h, ovf_h;
  logic [2:0] alushf_h;

  always #5 clk = ~clk;

  alk_shfseq #(.CNT_W(6), .DP_W(32)) dut (
    .clk       (clk),
    .reset_h   (reset_h),
    .start_h   (start_h),
    .cnt_h     (cnt_h),
    .mode_h    (mode_h),
    .stall_h   (stall_h),
    .abort_h   (abort_h),
    .msb_chg_h (msb_chg_h),
    .busy_h    (busy_h),
    .alushf_h  (alushf_h),
    .done_h    (done_h),
    .ovf_h     (ovf_h)
  );

  typedef struct {
    int         steps;
    logic [2:0] code;
    logic       ovf;
    bit         aborted;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  // Reference: steps and code straight from the shift rules.
  function automatic int model_steps(input int n, input logic [1:0] mode);
    int r;
    if (mode == 2'b10) begin
      r = n % 32;
      if (r < 0) r += 32;
      return r;
    end
    return (n < 0) ? -n : n;
  endfunction

  function automatic logic [2:0] model_code(input int n, input logic [1:0] mode);
    if (mode == 2'b10) return 3'b011;
    if (n >= 0)        return 3'b010;
    if (mode == 2'b01) return 3'b100;
    return 3'b001;
  endfunction

  // One request. stall_at: step index (steps = FIN) before which stall_len
  // stall cycles are inserted, -1 none. abort_at: step on which abort (or
  // reset if use_reset) is asserted, -1 none. chg: msb_chg_h per step.
  task automatic run_op(input int n, input logic [1:0] mode, input int stall_at,
                        input int stall_len, input int abort_at, input bit use_reset,
                        input logic [31:0] chg);
    int   steps;
    exp_t e;
    steps = model_steps(n, mode);
    e.steps = steps;
    e.code  = model_code(n, mode);
    e.ovf   = 1'b0;
    for (int i = 0; i < steps; i++)
      if (mode == 2'b01 && n > 0 && chg[i]) e.ovf = 1'b1;
    e.aborted = (abort_at >= 0) && (abort_at < steps);
    exp_q.push_back(e);
    start_h = 1'b1; cnt_h = n[5:0]; mode_h = mode;
    @(posedge clk); #1;
    start_h = 1'b0;
    for (int i = 0; i < steps; i++) begin
      if (i == stall_at) begin
        repeat (stall_len) begin
          stall_h = 1'b1; msb_chg_h = 1'($urandom); start_h = ($urandom_range(0, 3) == 0);
          @(posedge clk); #1;
        end
      end
      stall_h = 1'b0;
      if (i == abort_at) begin
        if (use_reset) reset_h = 1'b1; else abort_h = 1'b1;
        msb_chg_h = 1'b1;
        @(posedge clk); #1;
        reset_h = 1'b0; abort_h = 1'b0; start_h = 1'b0;
        chk(use_reset ? "reset_busy" : "abort_busy", busy_h, 0);
        chk(use_reset ? "reset_alushf" : "abort_alushf", alushf_h, 0);
        chk(use_reset ? "reset_done" : "abort_done", done_h, 0);
        chk(use_reset ? "reset_ovf" : "abort_ovf", ovf_h, 0);
        return;
      end
      msb_chg_h = chg[i];
      start_h   = ($urandom_range(0, 3) == 0);
      cnt_h     = 6'($urandom);
      mode_h    = 2'($urandom);
      @(posedge clk); #1;
    end
    if (stall_at == steps) begin
      repeat (stall_len) begin
        stall_h = 1'b1; msb_chg_h = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    stall_h = 1'b0; msb_chg_h = 1'($urandom); start_h = ($urandom_range(0, 1) == 0);
    @(posedge clk); #1;
    start_h = 1'b0;
  endtask

  // Monitor
  bit   prev_busy = 1'b0;
  bit   active    = 1'b0;
  int   k, stl, nstep;
  exp_t me;

  always @(negedge clk) begin
    if (busy_h === 1'b1) begin
      if (!prev_busy) begin k = 0; stl = 0; nstep = 0; active = 1'b1; end
      k++;
      if (done_h && !stall_h) begin
        if (exp_q.size() == 0) chk("spurious_done", 0, 1);
        else begin
          me = exp_q.pop_front();
          chk("unexpected_completion", me.aborted, 0);
          chk("latency", k - stl, me.steps + 1);
          chk("step_count", nstep, me.steps);
          chk("ovf", ovf_h, me.ovf);
          chk("wb30", alushf_h, 3'b110);
        end
        active = 1'b0;
      end else if (done_h) begin
        stl++;
      end else begin
        if (stall_h) stl++; else nstep++;
        if (exp_q.size() != 0) chk("step_code", alushf_h, exp_q[0].code);
      end
    end else begin
      if (active) begin
        if (exp_q.size() == 0) chk("spurious_op", 0, 1);
        else begin
          me = exp_q.pop_front();
          chk("missing_done", me.aborted, 1);
        end
        active = 1'b0;
      end
      if (!reset_h) begin
        chk("idle_nop", alushf_h, 0);
        chk("idle_no_done", done_h, 0);
      end
    end
    prev_busy = (busy_h === 1'b1);
  end

  initial begin
    logic signed [5:0] rn;
    int st_at, st_len, ab_at, stp;
    reset_h = 1'b1; start_h = 1'b0; stall_h = 1'b0; abort_h = 1'b0;
    msb_chg_h = 1'b0; cnt_h = '0; mode_h = '0;
    repeat (3) @(posedge clk);
    #1 reset_h = 1'b0;
    chk("rst_busy", busy_h, 0);
    chk("rst_alushf", alushf_h, 0);
    chk("rst_done", done_h, 0);
    chk("rst_ovf", ovf_h, 0);

    run_op(3,   2'b00, -1, 0, -1, 0, '0);
    run_op(-5,  2'b01, -1, 0, -1, 0, '1);
    run_op(-8,  2'b10, -1, 0, -1, 0, '0);
    run_op(0,   2'b00, -1, 0, -1, 0, '0);
    run_op(0,   2'b01, -1, 0, -1, 0, '0);
    run_op(0,   2'b10, -1, 0, -1, 0, '0);
    run_op(0,   2'b11, -1, 0, -1, 0, '0);
    run_op(2,   2'b01, -1, 0, -1, 0, 32'b10);
    run_op(1,   2'b00, -1, 0, -1, 0, '1);
    run_op(4,   2'b00,  2, 3, -1, 0, '0);
    run_op(-32, 2'b00, -1, 0,  1, 0, '0);
    run_op(10,  2'b11, -1, 0,  3, 1, '0);
    run_op(-32, 2'b01, -1, 0, -1, 0, '1);
    run_op(-32, 2'b10, -1, 0, -1, 0, '0);
    run_op(31,  2'b10, -1, 0, -1, 0, '0);
    run_op(-1,  2'b10, -1, 0, -1, 0, '0);
    run_op(31,  2'b01,  5, 2, -1, 0, 32'h8000_0000);
    run_op(3,   2'b01,  3, 2, -1, 0, '0);

    // start together with abort in IDLE is dropped
    start_h = 1'b1; abort_h = 1'b1; cnt_h = 6'd3; mode_h = 2'b00;
    @(posedge clk); #1;
    start_h = 1'b0; abort_h = 1'b0;
    chk("start_abort_idle", busy_h, 0);

    repeat (150) begin
      rn     = 6'($urandom);
      mode_h = 2'($urandom);
      stp    = model_steps(int'(rn), mode_h);
      st_at  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, stp) : -1;
      st_len = $urandom_range(1, 3);
      ab_at  = (stp > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, stp - 1) : -1;
      run_op(int'(rn), mode_h, st_at, st_len, ab_at, 1'($urandom), $urandom);
    end

    repeat (4) @(posedge clk);
    #1 chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
